// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response channel between one master and the data-memory arbiter
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  acc_type;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, addr, acc_type, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, acc_type, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter and one-shot sequencer for the 256-word data memory
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT  = 1024,
  parameter int          M0_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic          mem_W_en,
  output logic          mem_R_en,
  output logic [31:0]   mem_addr,
  output logic [2:0]    mem_RW_type,
  output logic [31:0]   mem_din,
  input  logic [31:0]   mem_dout,
  output logic [7:0]    err_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        last_id;
  logic        l_we;
  logic        l_id;
  logic        l_err;
  logic        rvalid0_q;
  logic        rvalid1_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        can_accept;
  logic        sel1;
  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic        w_we;
  logic [31:0] w_addr;
  logic [2:0]  w_type;
  logic [31:0] w_wdata;
  logic        w_err;

  // last_id=1 means m1 was granted last, so m0 takes the next tie.
  always_comb begin
    can_accept = ~rst & (state != ACCESS);
    sel1       = m1.req & (~m0.req | ((M0_PRIORITY == 0) & ~last_id));
    gnt0       = can_accept & m0.req & ~sel1;
    gnt1       = can_accept & sel1;
    accept     = gnt0 | gnt1;
    w_we       = sel1 ? m1.we       : m0.we;
    w_addr     = sel1 ? m1.addr     : m0.addr;
    w_type     = sel1 ? m1.acc_type : m0.acc_type;
    w_wdata    = sel1 ? m1.wdata    : m0.wdata;
    w_err      = ((w_type[1:0] == 2'b01) & w_addr[0])
               | (w_type[1] & (w_addr[1:0] != 2'b00))
               | (w_addr >= ADDR_LIMIT);
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rdata_q;
  assign m1.rdata  = rdata_q;
  assign m0.err    = err_q;
  assign m1.err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_id     <= 1'b1;
      l_we        <= 1'b0;
      l_id        <= 1'b0;
      l_err       <= 1'b0;
      mem_W_en    <= 1'b0;
      mem_R_en    <= 1'b0;
      mem_addr    <= 32'h0;
      mem_RW_type <= 3'h0;
      mem_din     <= 32'h0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      err_count   <= 8'h0;
    end else begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state)
        IDLE, RESP: state <= accept ? ACCESS : IDLE;
        ACCESS: begin
          mem_W_en  <= 1'b0;
          mem_R_en  <= 1'b0;
          rdata_q   <= (~l_we & ~l_err) ? mem_dout : 32'h0;
          err_q     <= l_err;
          rvalid0_q <= ~l_id;
          rvalid1_q <= l_id;
          if (l_err && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
      // Bus fields are launched on the grant edge so they are stable for the whole ACCESS cycle.
      if (accept) begin
        l_we        <= w_we;
        l_id        <= gnt1;
        l_err       <= w_err;
        last_id     <= gnt1;
        mem_addr    <= w_addr;
        mem_RW_type <= w_type;
        mem_din     <= w_wdata;
        mem_W_en    <= w_we & ~w_err;
        mem_R_en    <= ~w_we & ~w_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if m0_bus ();
  dmem_arbiter_if m1_bus ();
  dmem_arbiter_if p0_bus ();
  dmem_arbiter_if p1_bus ();

  logic        mem_W_en, mem_R_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [2:0]  mem_RW_type;
  logic [7:0]  err_count;
  logic        p_W_en, p_R_en;
  logic [31:0] p_addr, p_din;
  logic [31:0] p_dout;
  logic [2:0]  p_type;
  logic [7:0]  p_err_count;

  dmem_arbiter #(.ADDR_LIMIT(1024), .M0_PRIORITY(0)) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus),
    .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
    .mem_RW_type(mem_RW_type), .mem_din(mem_din), .mem_dout(mem_dout),
    .err_count(err_count));

  dmem_arbiter #(.ADDR_LIMIT(1024), .M0_PRIORITY(1)) dut_pri (
    .clk(clk), .rst(rst), .m0(p0_bus), .m1(p1_bus),
    .mem_W_en(p_W_en), .mem_R_en(p_R_en), .mem_addr(p_addr),
    .mem_RW_type(p_type), .mem_din(p_din), .mem_dout(p_dout),
    .err_count(p_err_count));

  assign p0_bus.req = m0_bus.req;   assign p1_bus.req = m1_bus.req;
  assign p0_bus.we = m0_bus.we;     assign p1_bus.we = m1_bus.we;
  assign p0_bus.addr = m0_bus.addr; assign p1_bus.addr = m1_bus.addr;
  assign p0_bus.acc_type = m0_bus.acc_type; assign p1_bus.acc_type = m1_bus.acc_type;
  assign p0_bus.wdata = m0_bus.wdata;       assign p1_bus.wdata = m1_bus.wdata;
  assign p_dout = 32'h0;

  int checks = 0;
  int errors = 0;
  int tcyc = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  // Memory lane semantics: little-endian byte/half/word, bit 2 of type selects zero-extension.
  function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(a)));
    h = 16'(w >> (16 * int'(a[1])));
    if (t[1]) return w;
    if (t[0]) return t[2] ? {16'h0, h} : {{16{h[15]}}, h};
    return t[2] ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] mem_write(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (t[1]) r = d;
    else if (t[0]) r[16 * int'(a[1]) +: 16] = d[15:0];
    else r[8 * int'(a) +: 8] = d[7:0];
    return r;
  endfunction

  function automatic bit addr_error(input logic [31:0] a, input logic [2:0] t);
    return (a >= 32'd1024) || (t[1:0] == 2'b01 && a[0]) || (t[1] && a[1:0] != 2'b00);
  endfunction

  logic [31:0] mem [256];
  logic [31:0] model_mem [256];
  initial for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; model_mem[i] = 32'h0; end

  assign mem_dout = mem_read(mem[mem_addr[9:2]], mem_addr[1:0], mem_RW_type);
  always @(posedge clk) if (mem_W_en) mem[mem_addr[9:2]] <= mem_write(mem[mem_addr[9:2]], mem_addr[1:0], mem_RW_type, mem_din);

  always @(posedge clk) tcyc <= tcyc + 1;

  // Transaction-level model: one access in flight, a new one may start two cycles after a grant.
  int          free_cyc = 0, pfree_cyc = 0, model_errs = 0, p1_while_m0 = 0;
  bit          last_m1 = 1'b1;
  bit          acc_v = 1'b0, resp_v = 1'b0;
  int          acc_cyc = 0, resp_cyc = 0;
  bit          acc_id, acc_we, acc_err, resp_id, resp_err;
  logic [31:0] acc_addr, acc_wdata, resp_rdata;
  logic [2:0]  acc_type;

  always @(negedge clk) begin
    logic e0, e1, pe0, pe1;
    logic [31:0] rd;
    if (rst) begin
      chk1("m0_gnt_in_rst", m0_bus.gnt, 1'b0);
      chk1("m1_gnt_in_rst", m1_bus.gnt, 1'b0);
      chk1("w_en_in_rst", mem_W_en, 1'b0);
      acc_v = 0; resp_v = 0; free_cyc = 0; pfree_cyc = 0; last_m1 = 1; model_errs = 0;
    end else begin
      e0 = 0; e1 = 0;
      if (tcyc >= free_cyc) begin
        if (m0_bus.req && m1_bus.req) begin
          if (last_m1) e0 = 1; else e1 = 1;
        end else if (m0_bus.req) e0 = 1;
        else if (m1_bus.req) e1 = 1;
      end
      chk1("m0_gnt", m0_bus.gnt, e0);
      chk1("m1_gnt", m1_bus.gnt, e1);

      if (acc_v && acc_cyc == tcyc) begin
        chk1("mem_W_en", mem_W_en, acc_we && !acc_err);
        chk1("mem_R_en", mem_R_en, !acc_we && !acc_err);
        chk32("mem_addr", mem_addr, acc_addr);
        chk32("mem_RW_type", {29'h0, mem_RW_type}, {29'h0, acc_type});
        chk32("mem_din", mem_din, acc_wdata);
        rd = 32'h0;
        if (!acc_err) begin
          if (acc_we) model_mem[acc_addr[9:2]] = mem_write(model_mem[acc_addr[9:2]], acc_addr[1:0], acc_type, acc_wdata);
          else rd = mem_read(model_mem[acc_addr[9:2]], acc_addr[1:0], acc_type);
        end
        resp_v = 1; resp_cyc = tcyc + 1; resp_id = acc_id; resp_rdata = rd; resp_err = acc_err;
        acc_v = 0;
      end else begin
        chk1("mem_W_en_idle", mem_W_en, 1'b0);
        chk1("mem_R_en_idle", mem_R_en, 1'b0);
      end

      if (resp_v && resp_cyc == tcyc) begin
        if (resp_err && model_errs < 255) model_errs++;
        chk1("m0_rvalid", m0_bus.rvalid, !resp_id);
        chk1("m1_rvalid", m1_bus.rvalid, resp_id);
        chk32("rdata", resp_id ? m1_bus.rdata : m0_bus.rdata, resp_rdata);
        chk1("err", resp_id ? m1_bus.err : m0_bus.err, resp_err);
        resp_v = 0;
      end else begin
        chk1("m0_rvalid_idle", m0_bus.rvalid, 1'b0);
        chk1("m1_rvalid_idle", m1_bus.rvalid, 1'b0);
      end
      chk32("err_count", {24'h0, err_count}, model_errs);

      if (e0 || e1) begin
        acc_v = 1; acc_cyc = tcyc + 1; acc_id = e1;
        acc_we    = e1 ? m1_bus.we : m0_bus.we;
        acc_addr  = e1 ? m1_bus.addr : m0_bus.addr;
        acc_type  = e1 ? m1_bus.acc_type : m0_bus.acc_type;
        acc_wdata = e1 ? m1_bus.wdata : m0_bus.wdata;
        acc_err   = addr_error(acc_addr, acc_type);
        free_cyc  = tcyc + 2;
        last_m1   = e1;
      end

      pe0 = (tcyc >= pfree_cyc) && m0_bus.req;
      pe1 = (tcyc >= pfree_cyc) && !m0_bus.req && m1_bus.req;
      chk1("pri_m0_gnt", p0_bus.gnt, pe0);
      chk1("pri_m1_gnt", p1_bus.gnt, pe1);
      if (pe0 || pe1) pfree_cyc = tcyc + 2;
      if (m0_bus.req && p1_bus.gnt) p1_while_m0++;
    end
  end

  task automatic drive(input bit id, input logic req, input logic we, input logic [31:0] addr,
                       input logic [2:0] t, input logic [31:0] wd);
    if (!id) begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr; m0_bus.acc_type = t; m0_bus.wdata = wd;
    end else begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr; m1_bus.acc_type = t; m1_bus.wdata = wd;
    end
  endtask

  task automatic do_req(input bit id, input logic we, input logic [31:0] addr, input logic [2:0] t,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    bit got;
    int gcyc;
    @(posedge clk); #1;
    drive(id, 1'b1, we, addr, t, wd);
    got = 0; gcyc = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (id ? m1_bus.gnt : m0_bus.gnt) begin got = 1; gcyc = tcyc; end
    end
    chk1("gnt_within_bound", got, 1'b1);
    @(posedge clk); #1;
    drive(id, 1'b0, we, addr, t, wd);
    got = 0; rd = 32'h0; er = 1'b0; lat = -1;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (id ? m1_bus.rvalid : m0_bus.rvalid) begin
        got = 1; lat = tcyc - gcyc;
        rd = id ? m1_bus.rdata : m0_bus.rdata;
        er = id ? m1_bus.err : m0_bus.err;
      end
    end
    chk1("rvalid_within_bound", got, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          gid [8];
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_W_en", mem_W_en, 1'b0);
    chk1("rst_R_en", mem_R_en, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_err_count", {24'h0, err_count}, 32'h0);
    chk32("rst_rdata", m0_bus.rdata, 32'h0);

    // Both masters hold loads: round-robin starting at m0.
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h0, 3'b010, 0);
    drive(1, 1, 0, 32'h4, 3'b010, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      gid[k] = m0_bus.gnt ? 0 : (m1_bus.gnt ? 1 : -1);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk32("tie_c0", gid[0], 0);
    chk32("tie_c1", gid[1], -1);
    chk32("tie_c2", gid[2], 1);
    chk32("tie_c4", gid[4], 0);
    chk32("tie_c6", gid[6], 1);
    chk32("tie_c7", gid[7], -1);
    repeat (2) @(posedge clk);

    do_req(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
    chk32("store_lat", lat, 2);
    do_req(0, 0, 32'h10, 3'b010, 0, rd, er, lat);
    chk32("load_rdata", rd, 32'hDEADBEEF);
    chk1("load_err", er, 1'b0);
    chk32("load_lat", lat, 2);

    do_req(1, 0, 32'h3, 3'b001, 0, rd, er, lat);
    chk1("misalign_err", er, 1'b1);
    chk32("misalign_rdata", rd, 32'h0);
    chk32("misalign_count", {24'h0, err_count}, 32'd1);
    do_req(1, 0, 32'h400, 3'b010, 0, rd, er, lat);
    chk1("range_err", er, 1'b1);
    chk32("range_count", {24'h0, err_count}, 32'd2);

    do_req(0, 1, 32'h20, 3'b010, 32'h000080FF, rd, er, lat);
    do_req(0, 0, 32'h20, 3'b000, 0, rd, er, lat);
    chk32("byte_signed", rd, 32'hFFFFFFFF);
    do_req(1, 0, 32'h20, 3'b101, 0, rd, er, lat);
    chk32("half_zext", rd, 32'h000080FF);

    // Randomized traffic from both masters, checked cycle by cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 15);
        if (r == 0) a = 32'd1024 + 32'($urandom_range(0, 4095));
        else if (r < 8) a = 32'($urandom_range(0, 15)) * 4;
        else a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        drive(m[0], $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a,
              3'($urandom_range(0, 7)), $urandom);
      end
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    chk32("err_count_saturated", {24'h0, err_count}, 32'd255);
    chk32("pri_m1_starved", p1_while_m0, 0);

    // Reset during the ACCESS cycle of a store must suppress the write and the response.
    do_req(0, 1, 32'h30, 3'b010, 32'h11223344, rd, er, lat);
    @(posedge clk); #1;
    drive(0, 1, 1, 32'h30, 3'b010, 32'hCAFEF00D);
    begin
      bit got;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (m0_bus.gnt) got = 1;
      end
      chk1("rst_test_gnt", got, 1'b1);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk32("rst_mem_unchanged", mem[12], 32'h11223344);
    chk1("post_rst_W_en", mem_W_en, 1'b0);
    chk1("post_rst_R_en", mem_R_en, 1'b0);
    chk32("post_rst_addr", mem_addr, 32'h0);
    chk32("post_rst_type", {29'h0, mem_RW_type}, 32'h0);
    chk32("post_rst_din", mem_din, 32'h0);
    chk1("post_rst_rvalid0", m0_bus.rvalid, 1'b0);
    chk1("post_rst_rvalid1", m1_bus.rvalid, 1'b0);
    chk32("post_rst_rdata", m0_bus.rdata, 32'h0);
    chk1("post_rst_err", m0_bus.err, 1'b0);
    chk32("post_rst_err_count", {24'h0, err_count}, 32'h0);
    repeat (3) @(posedge clk);
    do_req(1, 0, 32'h30, 3'b010, 0, rd, er, lat);
    chk32("post_rst_load", rd, 32'h11223344);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
